// File: rtl/cap_uart_uploader.sv
// cap_uart_uploader: drains the capture FIFO and sends each 48-bit word
// {i1,q1,i2,q2} as six 8N1 UART bytes on txd, most significant byte first.
// Optional feature: define CAP_UART_SYNC_HDR_EN to put a 0xA5 sync frame in
// front of every word, so the host can find word boundaries again.
module cap_uart_uploader #(
  parameter int ClkFrequency = 100000000,
  parameter int Baud         = 115200,
  parameter int DW           = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fifo_in,
  input  logic          fifo_emp,
  output logic          rd_fifo,
  output logic          txd,
  output logic          busy,
  output logic [15:0]   word_cnt
);

  localparam int DIV = ClkFrequency / Baud;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BYTE = 3'd5;
  localparam logic [3:0]    LAST_DATA = 4'd7;

`ifdef CAP_UART_SYNC_HDR_EN
  // Sync frame, bit 0 goes out first: start(0), 0xA5 LSB first, stop(1).
  localparam logic [9:0] HDR_FRAME    = {1'b1, 8'hA5, 1'b0};
  localparam logic [3:0] HDR_LAST_BIT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LATCH, S_HDR, S_START, S_DATA, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LATCH, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [2:0]    r_byte, w_byte_nxt;
  logic [DW-1:0] r_hold;
  logic          r_txd, w_txd_nxt;
  logic [15:0]   r_word_cnt, w_word_cnt_nxt;
  logic [7:0]    w_tx_byte;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Next-state decode: sequencing of pop, latch, frames and bit timing.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_word_cnt_nxt = r_word_cnt;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!fifo_emp) w_state_nxt = S_POP;
      end
      S_POP: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_byte_nxt = '0;
`ifdef CAP_UART_SYNC_HDR_EN
        w_state_nxt = S_HDR;
`else
        w_state_nxt = S_START;
`endif
      end
`ifdef CAP_UART_SYNC_HDR_EN
      S_HDR: begin
        if (w_bit_end) begin
          if (r_bit == HDR_LAST_BIT) begin
            w_state_nxt = S_START;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
`endif
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == LAST_DATA) w_state_nxt = S_STOP;
          else                    w_bit_nxt   = r_bit + 4'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte == LAST_BYTE) begin
            w_state_nxt    = S_IDLE;
            w_word_cnt_nxt = r_word_cnt + 16'd1;
          end else begin
            w_state_nxt = S_START;
            w_byte_nxt  = r_byte + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte to serialise, chosen by the upcoming byte index (MSB byte first).
  always_comb begin
    case (w_byte_nxt)
      3'd0:    w_tx_byte = r_hold[47:40];
      3'd1:    w_tx_byte = r_hold[39:32];
      3'd2:    w_tx_byte = r_hold[31:24];
      3'd3:    w_tx_byte = r_hold[23:16];
      3'd4:    w_tx_byte = r_hold[15:8];
      default: w_tx_byte = r_hold[7:0];
    endcase
  end

  // Line level for the next cycle, so txd comes straight from a flop.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
`ifdef CAP_UART_SYNC_HDR_EN
      S_HDR:   w_txd_nxt = HDR_FRAME[w_bit_nxt];
`endif
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_tx_byte[w_bit_nxt[2:0]];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // Control and line state; reset drops any word in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_txd      <= 1'b1;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_txd      <= w_txd_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  // Holding register: FIFO data is valid the cycle after the pop strobe.
  always_ff @(posedge clk) begin
    if (r_state == S_LATCH) r_hold <= fifo_in;
  end

  assign rd_fifo  = (r_state == S_POP);
  assign busy     = (r_state != S_IDLE);
  assign txd      = r_txd;
  assign word_cnt = r_word_cnt;

endmodule
